// File: rtl/serial_pair_serializer.sv
// serial_pair_serializer
// Parallel-to-serial transmitter feeding the serial comparators. Takes one
// (a, b) operand pair per valid/ready handshake and plays it out one bit per
// beat on out_a/out_b, MSB-first or LSB-first, tagging the first and last
// bit of every word so a downstream serial consumer can clear and capture.
//
// Optional build macro SERIAL_PAIR_GAP_EN: when defined, a new pair is only
// accepted from IDLE, so every word is followed by at least one idle cycle
// (one word per W+1 cycles). When undefined, a pair can be accepted on the
// last beat of the current word and words stream back-to-back.

module serial_pair_serializer #(
    parameter int W         = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_a,
    output logic         out_b,
    output logic         out_first,
    output logic         out_last
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic [W-1:0]   sh_a;
    logic [W-1:0]   sh_b;
    logic [W-1:0]   sh_a_next;
    logic [W-1:0]   sh_b_next;
    logic           accept;
    logic           beat;
    logic           at_last;

    // Handshake qualifiers shared by the FSM and the datapath
    always_comb begin
        at_last = (count == LAST_IDX);
        accept  = in_valid & in_ready;
        beat    = out_valid & out_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: an accept always (re)enters SHIFT, the last beat otherwise drops to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    state_next = SHIFT;
                end else if (beat && at_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from registered state only, except in_ready which must see rst and out_ready
    always_comb begin
        out_valid = (state == SHIFT);
        out_a     = MSB_FIRST ? sh_a[W-1] : sh_a[0];
        out_b     = MSB_FIRST ? sh_b[W-1] : sh_b[0];
        out_first = out_valid && (count == '0);
        out_last  = out_valid && at_last;
`ifdef SERIAL_PAIR_GAP_EN
        in_ready  = !rst && (state == IDLE);
`else
        in_ready  = !rst && ((state == IDLE) || (out_last && out_ready));
`endif
    end

    // Datapath next value: load on accept, shift and count on each beat, park the counter at 0 after the last beat
    always_comb begin
        sh_a_next  = sh_a;
        sh_b_next  = sh_b;
        count_next = count;
        if (accept) begin
            sh_a_next  = in_a;
            sh_b_next  = in_b;
            count_next = '0;
        end else if (beat) begin
            if (MSB_FIRST) begin
                sh_a_next = {sh_a[W-2:0], 1'b0};
                sh_b_next = {sh_b[W-2:0], 1'b0};
            end else begin
                sh_a_next = {1'b0, sh_a[W-1:1]};
                sh_b_next = {1'b0, sh_b[W-1:1]};
            end
            count_next = at_last ? '0 : count + CW'(1);
        end
    end

    // Datapath registers; zeros shifted in leave out_a/out_b low between words
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            count <= '0;
        end else begin
            sh_a  <= sh_a_next;
            sh_b  <= sh_b_next;
            count <= count_next;
        end
    end

endmodule

// File: doc/serial_pair_serializer.md
Name: serial_pair_serializer

Overview:
- Parallel-to-serial transmitter for the serial comparators.
- Accepts one pair of W-bit operands (a, b) per valid/ready handshake.
- Emits the pair one bit per clock on out_a and out_b, in MSB-first or LSB-first order.
- Marks the first and last bit of each word so a downstream serial consumer can clear its running state and capture its result.

Parameters:
- W, 16, operand width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = emit bit W-1 first, 0 = emit bit 0 first.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  parallel operand pair valid
- in_ready  output  1  block can accept a pair this cycle
- in_a  input  W  operand a
- in_b  input  W  operand b
- out_valid  output  1  serial bit pair valid
- out_ready  input  1  downstream consumes the current bit pair
- out_a  output  1  current bit of a
- out_b  output  1  current bit of b
- out_first  output  1  current bit is the first bit of its word
- out_last  output  1  current bit is the last bit of its word

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, counter = 0, shift registers = 0.
  - out_valid = 0, out_a = 0, out_b = 0, out_first = 0, out_last = 0.
  - in_ready = 0 while rst = 1.
- States:
  - IDLE: out_valid = 0, in_ready = 1.
  - SHIFT: out_valid = 1.
- Accept: in_valid & in_ready at an edge loads in_a/in_b into the shift registers, sets counter = 0 and enters SHIFT.
- Latency: the first bit appears on the outputs in the cycle after the accepting edge; all outputs are registered.
- Bit order:
  - MSB_FIRST = 1: out_a = sh_a[W-1]; the register shifts left on each beat.
  - MSB_FIRST = 0: out_a = sh_a[0]; the register shifts right on each beat.
  - out_b follows the same rule.
- Beat: a beat is out_valid & out_ready at an edge. Each beat advances the shift and increments the counter.
- Stall: while out_ready = 0, all outputs hold stable (AXI-style). out_valid never drops mid-word.
- Markers:
  - out_first = 1 exactly when counter = 0.
  - out_last = 1 exactly when counter = W-1.
  - Both flags are qualified by out_valid.
- End of word: a beat with out_last = 1 returns to IDLE, unless a new pair is accepted in the same cycle.
- Back-to-back: in_ready = (state == IDLE) | (out_last & out_ready). A simultaneous last beat and accept reloads directly, with no gap. Sustained throughput is one word per W cycles.
- in_valid while in_ready = 0 is ignored; the source holds in_valid and its data until accepted.
- Reset mid-word: the word is dropped, out_valid = 0 on the next cycle, and no partial-word flags are emitted afterwards.
- Counter width is $clog2(W) and never wraps past W-1.

Optional Feature:
- Macro: SERIAL_PAIR_GAP_EN.
- Defined:
  - in_ready = (state == IDLE) only, so the back-to-back path is removed.
  - Every word is followed by at least one cycle with out_valid = 0.
  - Throughput is one word per W+1 cycles.
  - Gives comparators that reset on the idle cycle a clean boundary.
- Undefined: back-to-back behaviour exactly as described in Behaviour.

Test Plan:
- Reset held 4 cycles, then released -> out_valid = 0 and in_ready = 1 in the first cycle after release.
- W = 16, MSB_FIRST = 1, in_a = 16'h6482, in_b = 16'h6262, out_ready = 1:
  - out_a sequence is 0110_0100_1000_0010 and out_b sequence is 0110_0010_0110_0010.
  - out_first is high on beat 0 only; out_last is high on beat 15 only.
  - A downstream MSB-first comparator reports eq for 5 beats, then greater.
- Same operands with MSB_FIRST = 0 -> out_a sequence is 0100_0001_0010_0110 (bit 0 first).
- out_ready low for 3 cycles at beat 7 -> outputs frozen at the beat-7 values and the word still totals 16 beats.
- Two pairs offered back-to-back (0xFFFF/0x0000, then 0x0001/0x0001):
  - Without the macro: the second word's out_first follows the first word's out_last with no gap (32 consecutive valid cycles).
  - With SERIAL_PAIR_GAP_EN: exactly one out_valid = 0 cycle between the words.
- rst asserted at beat 9 -> out_valid = 0 on the next cycle. A new pair after release starts cleanly with out_first = 1.
